byte_pair_packer: RTL and testbench

Upstream feeder for the 8-bit concatenate/replicate stage. Accepts a byte stream over a valid/ready handshake and pairs consecutive bytes into (num1, num2) tuples, first byte on num1. Buffers pairs in a small FIFO so the consumer can stall without losing data. An odd trailing byte is flushed with a pad byte when the producer marks the last byte of a burst.

---
 rtl/byte_pair_pkg.sv | 20 ++
 rtl/byte_pair_packer_if.sv | 27 ++
 rtl/byte_pair_packer_pair_fifo.sv | 64 ++++++
 rtl/byte_pair_packer.sv | 107 ++++++++++
 tb/tb_byte_pair_packer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_pair_pkg.sv
// Shared types and constants for the byte pair packer: pairing FSM states,
// the FIFO entry layout and the datapath widths.
package byte_pair_pkg;

    localparam int BYTE_W     = 8;
    localparam int PAIR_CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pair_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] num1;
        logic [BYTE_W-1:0] num2;
        logic              last;
        logic              odd;
    } pair_t;

endpackage

// File: rtl/byte_pair_packer_if.sv
// Byte stream in, pair stream out. The packer uses the slave view and the
// producer/consumer environment uses the master view.
interface byte_pair_packer_if;
    import byte_pair_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [BYTE_W-1:0] num1;
    logic [BYTE_W-1:0] num2;
    logic              pair_last;
    logic              pair_odd;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, num1, num2, pair_last, pair_odd, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, num1, num2, pair_last, pair_odd, out_valid
    );

endinterface

// File: rtl/byte_pair_packer_pair_fifo.sv
// Register-array synchronous FIFO of pair entries with full flag and
// occupancy count; pushes on full and pops on empty are ignored.
module pair_fifo
    import byte_pair_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  pair_t                  wr_data,
    input  logic                   pop,
    output pair_t                  rd_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    pair_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset; the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/byte_pair_packer.sv
// Pairs consecutive bytes into (num1, num2) entries buffered in a small FIFO;
// an odd last byte is flushed with PAD. Define PAIR_CNT_EN to add pair_cnt.
module byte_pair_packer
    import byte_pair_pkg::*;
#(
    parameter int                DEPTH = 4,
    parameter logic [BYTE_W-1:0] PAD   = 8'h00
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    byte_pair_packer_if.slave      bus
`ifdef PAIR_CNT_EN
    ,
    output logic [PAIR_CNT_W-1:0]  pair_cnt
`endif
);

    pair_state_e            state_reg;
    pair_state_e            state_next;
    logic [BYTE_W-1:0]      hold_reg;
    logic [BYTE_W-1:0]      hold_next;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    pair_t                  push_data;
    pair_t                  head;

    // in_ready depends only on the FIFO fill level, never on out_ready.
    assign bus.in_ready = !fifo_full;
    assign accept       = bus.in_valid && !fifo_full;
    assign pop          = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        push       = 1'b0;
        push_data  = '{num1: hold_reg, num2: bus.in_data, last: bus.in_last, odd: 1'b0};
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    if (bus.in_last) begin
                        push      = 1'b1;
                        push_data = '{num1: bus.in_data, num2: PAD, last: 1'b1, odd: 1'b1};
                    end else begin
                        hold_next  = bus.in_data;
                        state_next = HALF;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    push       = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Head fields read as zero while nothing is buffered.
    assign bus.out_valid = (fifo_count != '0);
    assign bus.num1      = bus.out_valid ? head.num1 : '0;
    assign bus.num2      = bus.out_valid ? head.num2 : '0;
    assign bus.pair_last = bus.out_valid && head.last;
    assign bus.pair_odd  = bus.out_valid && head.odd;

`ifdef PAIR_CNT_EN
    logic [PAIR_CNT_W-1:0] pair_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt_reg <= '0;
        end else if (pop) begin
            pair_cnt_reg <= pair_cnt_reg + 16'd1;
        end
    end

    assign pair_cnt = pair_cnt_reg;
`endif

endmodule

// File: tb/tb_byte_pair_packer.sv
// Self-checking bench for byte_pair_packer: directed scenarios plus random
// streams checked against a queue-based pairing model.
module tb_byte_pair_packer;
    import byte_pair_pkg::*;

    localparam int        DEPTH = 4;
    localparam logic [7:0] PAD  = 8'h00;

    typedef struct {
        logic [7:0] n1;
        logic [7:0] n2;
        logic       last;
        logic       odd;
    } exp_pair_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    byte_pair_packer_if bus();
`ifdef PAIR_CNT_EN
    logic [15:0] pair_cnt;
`endif

    byte_pair_packer #(
        .DEPTH (DEPTH),
        .PAD   (PAD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PAIR_CNT_EN
        ,
        .pair_cnt (pair_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Presents one byte and holds it until accepted (bounded); returns at the negedge after accept.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        total++;
        if (waited >= 50) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b required 1 for byte %02h", bus.in_ready, d);
        end
        @(posedge clk);
        @(negedge clk);
        $display("byte %02h last=%b accepted", d, l);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.in_ready, bus.out_valid, bus.pair_last, bus.pair_odd} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got rdy/vld/last/odd=%b required 1000",
                     {bus.in_ready, bus.out_valid, bus.pair_last, bus.pair_odd});
        end
        total++;
        if ({bus.num1, bus.num2} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data: got %02h/%02h required 00/00", bus.num1, bus.num2);
        end
`ifdef PAIR_CNT_EN
        total++;
        if (pair_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL reset_pair_cnt: got %0d required 0", pair_cnt);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_basic_pair();
        bus.out_ready = 1'b1;
        send_byte(8'hA1, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_half_valid: got %b required 0", bus.out_valid);
        end
        send_byte(8'hB2, 1'b0);
        total++;
        if ({bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd} !== {1'b1, 8'hA1, 8'hB2, 2'b00}) begin
            bad++;
            $display("FAIL basic_pair: got v=%b %02h/%02h l=%b o=%b required v=1 a1/b2 l=0 o=0",
                     bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_popped: out_valid=%b required 0", bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_odd_flush();
        bus.out_ready = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        total++;
        if ({bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd} !== {1'b1, 8'h11, 8'h22, 2'b00}) begin
            bad++;
            $display("FAIL odd_first: got v=%b %02h/%02h l=%b o=%b required v=1 11/22 l=0 o=0",
                     bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd} !== {1'b1, 8'h33, PAD, 2'b11}) begin
            bad++;
            $display("FAIL odd_flush: got v=%b %02h/%02h l=%b o=%b required v=1 33/%02h l=1 o=1",
                     bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd, PAD);
        end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL odd_drained: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int   got   = 0;
        logic sent9 = 1'b0;
        logic first = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 2 * DEPTH; i++) send_byte(8'(i), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h09;
        bus.in_last  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if ({bus.in_ready, bus.out_valid, bus.num1, bus.num2} !== {1'b0, 1'b1, 8'h01, 8'h02}) begin
            bad++;
            $display("FAIL full_stall: got rdy=%b v=%b %02h/%02h required rdy=0 v=1 01/02",
                     bus.in_ready, bus.out_valid, bus.num1, bus.num2);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < DEPTH; c++) begin
            if (bus.out_valid === 1'b1) begin
                total++;
                if ({bus.num1, bus.num2, bus.pair_last, bus.pair_odd} !== {8'(2 * got + 1), 8'(2 * got + 2), 2'b00}) begin
                    bad++;
                    $display("FAIL drain_pair%0d: got %02h/%02h l=%b o=%b required %02h/%02h l=0 o=0", got,
                             bus.num1, bus.num2, bus.pair_last, bus.pair_odd, 8'(2 * got + 1), 8'(2 * got + 2));
                end
                $display("pop %02h/%02h", bus.num1, bus.num2);
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent9 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (sent9) bus.in_valid = 1'b0;
            if (first) begin
                first = 1'b0;
                total++;
                if (bus.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL ready_after_pop: in_ready=%b required 1", bus.in_ready);
                end
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++;
        if (got !== DEPTH || sent9 !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_count: got pairs=%0d byte09=%b v=%b required pairs=%0d byte09=1 v=0",
                     got, sent9, bus.out_valid, DEPTH);
        end
        send_byte(8'h0A, 1'b1);
        total++;
        if ({bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd} !== {1'b1, 8'h09, 8'h0A, 2'b10}) begin
            bad++;
            $display("FAIL held_byte_pair: got v=%b %02h/%02h l=%b o=%b required v=1 09/0a l=1 o=0",
                     bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // Random stream against a queue model: pairs form from accepted bytes by rule, not by RTL state.
    task automatic test_random_stream(input int n, input int vpct, input int rpct, input int lpct, input int fill);
        exp_pair_t  q[$];
        logic [7:0] pend[$];
        exp_pair_t  p;
        logic       pop_now;
        logic       acc_now;
        logic       drain;
        for (int c = 0; c < n + 40; c++) begin
            drain = (c >= n);
            if (drain && q.size() == 0 && pend.size() == 0) break;
            total++;
            if (bus.out_valid !== (q.size() != 0)) begin
                bad++;
                $display("FAIL rnd_valid c=%0d: got %b required %b", c, bus.out_valid, q.size() != 0);
            end
            total++;
            if (bus.in_ready !== (q.size() < DEPTH)) begin
                bad++;
                $display("FAIL rnd_ready c=%0d: got %b required %b", c, bus.in_ready, q.size() < DEPTH);
            end
            if (q.size() != 0) begin
                total++;
                if ({bus.num1, bus.num2, bus.pair_last, bus.pair_odd} !== {q[0].n1, q[0].n2, q[0].last, q[0].odd}) begin
                    bad++;
                    $display("FAIL rnd_head c=%0d: got %02h/%02h l=%b o=%b required %02h/%02h l=%b o=%b", c,
                             bus.num1, bus.num2, bus.pair_last, bus.pair_odd, q[0].n1, q[0].n2, q[0].last, q[0].odd);
                end
            end
            if (!drain) begin
                bus.in_valid  = ($urandom_range(99) < vpct);
                bus.in_data   = 8'($urandom);
                bus.in_last   = ($urandom_range(99) < lpct);
                bus.out_ready = (c < fill) ? 1'b0 : ($urandom_range(99) < rpct);
            end else begin
                bus.in_valid  = (pend.size() != 0);
                bus.in_data   = 8'($urandom);
                bus.in_last   = 1'b1;
                bus.out_ready = 1'b1;
            end
            pop_now = bus.out_ready && (q.size() != 0);
            acc_now = bus.in_valid && (q.size() < DEPTH);
            @(posedge clk);
            if (pop_now) begin
                $display("pop %02h/%02h last=%b odd=%b", q[0].n1, q[0].n2, q[0].last, q[0].odd);
                void'(q.pop_front());
            end
            if (acc_now) begin
                pend.push_back(bus.in_data);
                if (pend.size() == 2) begin
                    p = '{n1: pend[0], n2: pend[1], last: bus.in_last, odd: 1'b0};
                    q.push_back(p);
                    pend.delete();
                end else if (bus.in_last) begin
                    p = '{n1: pend[0], n2: PAD, last: 1'b1, odd: 1'b1};
                    q.push_back(p);
                    pend.delete();
                end
            end
            @(negedge clk);
        end
        total++;
        if (q.size() != 0 || pend.size() != 0) begin
            bad++;
            $display("FAIL rnd_drain: pairs left=%0d bytes left=%0d required 0/0", q.size(), pend.size());
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Fill the FIFO with out_ready low, then run in_valid and out_ready continuously high.
        test_random_stream(80, 100, 100, 10, 10);
    endtask

    task automatic test_reset_mid_burst();
        bus.out_ready = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h5A, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid: got %b required 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL async_reset: got v=%b rdy=%b required v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hD4, 1'b0);
        total++;
        if ({bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd} !== {1'b1, 8'hC3, 8'hD4, 2'b00}) begin
            bad++;
            $display("FAIL post_reset_pair: got v=%b %02h/%02h l=%b o=%b required v=1 c3/d4 l=0 o=0",
                     bus.out_valid, bus.num1, bus.num2, bus.pair_last, bus.pair_odd);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_single: out_valid=%b required 0", bus.out_valid);
        end
    endtask

`ifdef PAIR_CNT_EN
    task automatic test_pair_cnt();
        test_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (pair_cnt !== 16'd3) begin
            bad++;
            $display("FAIL pair_cnt_three: got %0d required 3", pair_cnt);
        end
        bus.out_ready = 1'b0;
        force dut.pair_cnt_reg = 16'hFFFF;
        #1;
        release dut.pair_cnt_reg;
        #1;
        total++;
        if (pair_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL pair_cnt_preload: got %04h required ffff", pair_cnt);
        end
        @(negedge clk);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (pair_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL pair_cnt_wrap: got %04h required 0000", pair_cnt);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_pair();
        test_odd_flush();
        test_backpressure();
        test_back_to_back();
        test_random_stream(300, 60, 50, 15, 0);
        test_random_stream(200, 90, 30, 5, 0);
        test_reset_mid_burst();
`ifdef PAIR_CNT_EN
        test_pair_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
